spi_track_loader: RTL
=====================

# spi_track_loader

SPI slave front end for the tone-generator array. It receives one packet of `PACKET_SIZE` bits per track over a three-wire link (`cs`, `sck`, `sdi`) that is asynchronous to `clk`. On a complete frame it commits per-track half-period and amplitude settings atomically to the tone generators downstream. Malformed frames are rejected and the previously committed settings stay in effect.

## Interface
- `NUM_INPUTS`, default 1: number of tracks, i.e. the number of packets per frame.
- `PACKET_SIZE`, default 24: bits per track packet. Fixed layout: `[23:8]` is the half-period in `clk` cycles, `[7:0]` is the amplitude.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low; clock `clk`.
- `cs`  in  1  frame enable, asynchronous, active-high; a frame is the interval while `cs` is high.
- `sck`  in  1  serial clock, asynchronous; data is sampled on its rising edge.
- `sdi`  in  1  serial data, MSB first.
- `period`  out  `16*NUM_INPUTS`  committed half-periods; track k is at `[16k+15:16k]`.
- `amp`  out  `8*NUM_INPUTS`  committed amplitudes; track k is at `[8k+7:8k]`.
- `update`  out  1  one-cycle pulse when new settings are committed.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Synchronisation:
  - `cs`, `sck` and `sdi` each pass through a 2-flop synchroniser.
  - A third register on `cs` and `sck` provides edge detection.
  - All synchroniser flops reset to 0. A `cs` held high through reset release is therefore seen as a frame start.
- Frame length: N = `PACKET_SIZE*NUM_INPUTS`. The first bit received goes to the MSB of track `NUM_INPUTS-1`'s packet, so a 96-bit frame lists track 3 first. Within a track, bit 23 is sent first.
- State machine:
  - IDLE: on a `cs` rise, clear the bit counter and shadow register, then go to SHIFT. `sck` edges are ignored in IDLE.
  - SHIFT: on each `sck` rise, shift the synchronised `sdi` into the N-bit shadow register LSB and increment the counter. The counter saturates at N+1.
  - SHIFT to COMMIT on a `cs` fall.
  - COMMIT (one cycle):
    - If count == N, load `period`/`amp` from the shadow register and pulse `update`.
    - Otherwise, pulse `frame_err` and leave the outputs unchanged.
    - Always return to IDLE.
- Simultaneous events:
  - A `cs` fall and an `sck` rise detected in the same cycle: the bit is shifted first, then the frame ends.
  - A `cs` rise in COMMIT is ignored. The master must keep `cs` low for at least 2 `clk` cycles between frames.
- Reset (in any state, including mid-frame): go to IDLE and clear the counter, shadow register, `period`, `amp`, `update` and `frame_err`. Amplitude 0 means silence downstream.

## Timing
- An `sck` pin edge is detected on the 3rd `clk` rising edge after it. The same applies to `cs`.
- `sdi` must be stable for at least 2 `clk` cycles before and at least 2 after the `sck` rising edge.
- `sck` high and low times must each be at least 3 `clk` periods.
- From the `cs` pin fall to a valid `period`/`amp` and the `update` pulse is 4 `clk` edges: 3 for detection plus 1 for COMMIT.
- `period`/`amp` change only in COMMIT. All tracks update in the same cycle.
- `update` and `frame_err` are never both high. Each is high for exactly one cycle per frame.

## Structure
- Package `hdr_pkg`:
  - `PACKET_SIZE`, `PERIOD_W`=16, `AMP_W`=8.
  - `track_cfg_t` struct {period, amp}.
  - The state enum (IDLE, SHIFT, COMMIT). It is shared with `top` for debug.
- Sub-module `sync2`: a 2-flop synchroniser with a reset value parameter. It is instantiated 3 times.
- The remainder is roughly 150–250 lines: the edge detect, FSM, counter, shadow register and output registers.

## Test plan
- `NUM_INPUTS`=1, frame 24'h0114ff → `period`=16'h0114, `amp`=8'hff, a single `update` pulse 4 cycles after the `cs` fall, `frame_err` stays 0.
- `NUM_INPUTS`=4, frame 96'h0114ff0217ff0114ff0217ff:
  - Track 3 and track 1 → `period` 16'h0114, `amp` 8'hff.
  - Track 2 and track 0 → `period` 16'h0217, `amp` 8'hff.
  - All tracks update in the same cycle.
- After loading 24'h0114ff, send a 23-bit frame, then a 25-bit frame → two `frame_err` pulses, no `update`, outputs still 16'h0114 / 8'hff.
- Assert reset after 10 bits of a frame → all outputs are 0 on the next cycle. After release, a full frame 24'h0217ff commits 16'h0217 / 8'hff.
- Toggle `sck` 30 times with `sdi`=1 while `cs` is low → no shift, no pulse, outputs unchanged. A following valid frame commits normally.

Source files
------------

// File: rtl/hdr_pkg.sv
// rtl/hdr_pkg.sv - shared types and widths for the SPI track loader
package hdr_pkg;

  localparam int PACKET_SIZE = 24;
  localparam int PERIOD_W    = 16;
  localparam int AMP_W       = 8;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [AMP_W-1:0]    amp;
  } track_cfg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for an asynchronous single-bit input
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_track_loader.sv
// rtl/spi_track_loader.sv - SPI slave that shifts in a frame of track packets and commits them atomically
module spi_track_loader #(
  parameter int NUM_INPUTS  = 1,
  parameter int PACKET_SIZE = hdr_pkg::PACKET_SIZE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cs,
  input  logic                                 sck,
  input  logic                                 sdi,
  output logic [hdr_pkg::PERIOD_W*NUM_INPUTS-1:0] period,
  output logic [hdr_pkg::AMP_W*NUM_INPUTS-1:0]    amp,
  output logic                                 update,
  output logic                                 frame_err
);

  import hdr_pkg::PERIOD_W;
  import hdr_pkg::AMP_W;
  import hdr_pkg::track_cfg_t;
  import hdr_pkg::state_t;
  import hdr_pkg::IDLE;
  import hdr_pkg::SHIFT;
  import hdr_pkg::COMMIT;

  localparam int N     = PACKET_SIZE * NUM_INPUTS;
  localparam int CNT_W = $clog2(N + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(N + 1);

  logic cs_s, sck_s, sdi_s;
  logic cs_prev_q, sck_prev_q;
  logic cs_rise, cs_fall, sck_rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic             update_q, update_d;
  logic             err_q, err_d;
  logic             load_en;
  track_cfg_t       cfg_q [NUM_INPUTS];

  sync2 #(.RESET_VAL(1'b0)) u_sync_cs  (.clk(clk), .reset(reset), .d_i(cs),  .q_o(cs_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_sck (.clk(clk), .reset(reset), .d_i(sck), .q_o(sck_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_sdi (.clk(clk), .reset(reset), .d_i(sdi), .q_o(sdi_s));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_prev_q  <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          cnt_d    = '0;
          shadow_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // A bit arriving with the cs fall still belongs to this frame.
        if (sck_rise) begin
          shadow_d = {shadow_q[N-2:0], sdi_s};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (cs_fall) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (cnt_q == CNT_FULL) begin
          update_d = 1'b1;
          load_en  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet k sits at shadow[k*PACKET_SIZE +: PACKET_SIZE]; the first track sent lands highest.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        cfg_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      update_q <= update_d;
      err_q    <= err_d;
      if (load_en) begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          cfg_q[k].period <= shadow_q[k*PACKET_SIZE + AMP_W +: PERIOD_W];
          cfg_q[k].amp    <= shadow_q[k*PACKET_SIZE +: AMP_W];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_out
    assign period[k*PERIOD_W +: PERIOD_W] = cfg_q[k].period;
    assign amp[k*AMP_W +: AMP_W]          = cfg_q[k].amp;
  end

  assign update    = update_q;
  assign frame_err = err_q;

endmodule
